// File: rtl/instruction_mem_sync.sv
// Synchronous instruction memory with a registered fetch port, a load port
// and a hardware clear sequencer. After reset the sequencer writes
// FILL_VALUE to every word, then the block sits in IDLE serving fetches and
// loads.
module instruction_mem_sync #(
  parameter int                     INSTR_WIDTH = 8,
  parameter int                     PC_WIDTH    = 8,
  parameter int                     DEPTH       = 256,
  parameter logic [INSTR_WIDTH-1:0] FILL_VALUE  = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   fetch_req,
  input  logic [PC_WIDTH-1:0]    pc,
  output logic                   fetch_ready,
  output logic [INSTR_WIDTH-1:0] instruction,
  output logic                   instr_valid,
  output logic                   fetch_fault,
  input  logic                   load_valid,
  input  logic [PC_WIDTH-1:0]    load_addr,
  input  logic [INSTR_WIDTH-1:0] load_data,
  output logic                   load_ready,
  output logic                   busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One extra bit so that DEPTH == 2**PC_WIDTH is representable.
  localparam logic [PC_WIDTH:0] DEPTH_W = (PC_WIDTH+1)'(DEPTH);
  localparam logic [PC_WIDTH:0] LAST_W  = DEPTH_W - 1'b1;

  typedef enum logic {S_CLEAR, S_IDLE} state_t;

  state_t                 state, state_nxt;
  logic [PC_WIDTH:0]      clr_cnt, clr_cnt_nxt;
  logic [INSTR_WIDTH-1:0] mem [DEPTH];

  logic                   idle;
  logic                   fetch_in_range, load_in_range;
  logic                   fetch_go, load_go;
  logic                   wr_en;
  logic [AW-1:0]          wr_addr;
  logic [INSTR_WIDTH-1:0] wr_data;

  assign idle        = (state == S_IDLE);
  assign fetch_ready = idle;
  assign load_ready  = idle;
  assign busy        = !idle;

  // Full-width unsigned compare: addresses never wrap into the array.
  assign fetch_in_range = ({1'b0, pc} < DEPTH_W);
  assign load_in_range  = ({1'b0, load_addr} < DEPTH_W);
  assign fetch_go       = idle && fetch_req;
  assign load_go        = idle && load_valid && load_in_range;

  // Single write port shared by the clear sequencer and the loader.
  assign wr_en   = !idle || load_go;
  assign wr_addr = idle ? load_addr[AW-1:0] : clr_cnt[AW-1:0];
  assign wr_data = idle ? load_data : FILL_VALUE;

  // State and clear counter; reset always restarts the clear from 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_CLEAR;
      clr_cnt <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
    end
  end

  // Next state: walk the counter through the array, then drop into IDLE.
  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    if (state == S_CLEAR) begin
      clr_cnt_nxt = clr_cnt + 1'b1;
      if (clr_cnt == LAST_W) state_nxt = S_IDLE;
    end
  end

  // Array write port, no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Registered read port; sees the array before this edge's write, giving
  // read-before-write on a same-address collision.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instruction <= '0;
      instr_valid <= 1'b0;
      fetch_fault <= 1'b0;
    end else if (fetch_go) begin
      instr_valid <= 1'b1;
      fetch_fault <= !fetch_in_range;
      instruction <= fetch_in_range ? mem[pc[AW-1:0]] : FILL_VALUE;
    end else begin
      instr_valid <= 1'b0;
      fetch_fault <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instruction_mem_sync.sv
// Directed bench: a full-depth instance (DEPTH=256, fill 0x00) and a short
// instance (DEPTH=16, fill 0x5A) share the same stimulus.
module tb_instruction_mem_sync;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       fetch_req = 1'b0;
  logic [7:0] pc = '0;
  logic       load_valid = 1'b0;
  logic [7:0] load_addr = '0;
  logic [7:0] load_data = '0;

  logic       fr_a, lr_a, busy_a, iv_a, ff_a;
  logic [7:0] in_a;
  logic       fr_b, lr_b, busy_b, iv_b, ff_b;
  logic [7:0] in_b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  instruction_mem_sync #(.INSTR_WIDTH(8), .PC_WIDTH(8), .DEPTH(256),
                         .FILL_VALUE(8'h00)) u_a (
    .clk(clk), .reset(reset), .fetch_req(fetch_req), .pc(pc),
    .fetch_ready(fr_a), .instruction(in_a), .instr_valid(iv_a),
    .fetch_fault(ff_a), .load_valid(load_valid), .load_addr(load_addr),
    .load_data(load_data), .load_ready(lr_a), .busy(busy_a));

  instruction_mem_sync #(.INSTR_WIDTH(8), .PC_WIDTH(8), .DEPTH(16),
                         .FILL_VALUE(8'h5A)) u_b (
    .clk(clk), .reset(reset), .fetch_req(fetch_req), .pc(pc),
    .fetch_ready(fr_b), .instruction(in_b), .instr_valid(iv_b),
    .fetch_fault(ff_b), .load_valid(load_valid), .load_addr(load_addr),
    .load_data(load_data), .load_ready(lr_b), .busy(busy_b));

  typedef struct {
    logic       freq;
    logic [7:0] pc;
    logic       lv;
    logic [7:0] la;
    logic [7:0] ld;
    logic       ev;
    logic [7:0] ei;
    logic       ef;
  } vec_t;

  vec_t tbl [20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic f, input logic [7:0] p, input logic l,
                       input logic [7:0] a, input logic [7:0] d);
    fetch_req = f; pc = p; load_valid = l; load_addr = a; load_data = d;
  endtask

  // Release reset and count edges until each instance leaves CLEAR, while
  // pushing fetch/load requests that must be ignored.
  task automatic clear_wait(input string tag);
    int n = 0, na = 0, nb = 0, spur = 0;
    reset = 1'b0;
    drive(1'b1, 8'h05, 1'b1, 8'h05, 8'hFF);
    while (na == 0 && n < 400) begin
      tick();
      n++;
      if (iv_a) spur++;
      if (nb == 0 && busy_b && iv_b) spur++;
      if (nb == 0 && !busy_b) nb = n;
      if (na == 0 && !busy_a) na = n;
    end
    drive(1'b0, 8'h00, 1'b0, 8'h00, 8'h00);
    chk({tag, "_clear_len_256"}, na, 256);
    chk({tag, "_clear_len_16"}, nb, 16);
    chk({tag, "_no_valid_in_clear"}, spur, 0);
    chk({tag, "_ready_after_clear"}, {fr_a, lr_a, busy_a}, 3'b110);
  endtask

  initial begin
    //            freq pc    lv la    ld    ev ei    ef
    tbl[0]  = '{1'b1, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 8'h00, 1'b0};
    tbl[1]  = '{1'b1, 8'h7F, 1'b0, 8'h00, 8'h00, 1'b1, 8'h00, 1'b0};
    tbl[2]  = '{1'b1, 8'hFF, 1'b0, 8'h00, 8'h00, 1'b1, 8'h00, 1'b0};
    tbl[3]  = '{1'b1, 8'h05, 1'b0, 8'h00, 8'h00, 1'b1, 8'h00, 1'b0};
    tbl[4]  = '{1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    tbl[5]  = '{1'b0, 8'h00, 1'b1, 8'h10, 8'h3C, 1'b0, 8'h00, 1'b0};
    tbl[6]  = '{1'b1, 8'h10, 1'b0, 8'h00, 8'h00, 1'b1, 8'h3C, 1'b0};
    tbl[7]  = '{1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 8'h3C, 1'b0};
    tbl[8]  = '{1'b0, 8'h00, 1'b1, 8'h01, 8'hA1, 1'b0, 8'h3C, 1'b0};
    tbl[9]  = '{1'b0, 8'h00, 1'b1, 8'h02, 8'hA2, 1'b0, 8'h3C, 1'b0};
    tbl[10] = '{1'b0, 8'h00, 1'b1, 8'h03, 8'hA3, 1'b0, 8'h3C, 1'b0};
    tbl[11] = '{1'b1, 8'h01, 1'b0, 8'h00, 8'h00, 1'b1, 8'hA1, 1'b0};
    tbl[12] = '{1'b1, 8'h02, 1'b0, 8'h00, 8'h00, 1'b1, 8'hA2, 1'b0};
    tbl[13] = '{1'b1, 8'h03, 1'b0, 8'h00, 8'h00, 1'b1, 8'hA3, 1'b0};
    tbl[14] = '{1'b0, 8'h00, 1'b1, 8'h20, 8'h11, 1'b0, 8'hA3, 1'b0};
    tbl[15] = '{1'b1, 8'h20, 1'b1, 8'h20, 8'h22, 1'b1, 8'h11, 1'b0};
    tbl[16] = '{1'b1, 8'h20, 1'b0, 8'h00, 8'h00, 1'b1, 8'h22, 1'b0};
    tbl[17] = '{1'b1, 8'h30, 1'b1, 8'h31, 8'h99, 1'b1, 8'h00, 1'b0};
    tbl[18] = '{1'b1, 8'h31, 1'b0, 8'h00, 8'h00, 1'b1, 8'h99, 1'b0};
    tbl[19] = '{1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 8'h99, 1'b0};

    // Reset state
    reset = 1'b1;
    tick(); tick();
    chk("rst_outputs_a", {in_a, iv_a, ff_a}, 10'h000);
    chk("rst_ctrl_a", {fr_a, lr_a, busy_a}, 3'b001);
    chk("rst_ctrl_b", {fr_b, lr_b, busy_b}, 3'b001);
    @(negedge clk);
    clear_wait("init");

    // Main table on the full-depth instance
    foreach (tbl[i]) begin
      drive(tbl[i].freq, tbl[i].pc, tbl[i].lv, tbl[i].la, tbl[i].ld);
      tick();
      chk($sformatf("vec%0d_valid", i), iv_a, tbl[i].ev);
      chk($sformatf("vec%0d_instr", i), in_a, tbl[i].ei);
      chk($sformatf("vec%0d_fault", i), ff_a, tbl[i].ef);
    end
    drive(1'b0, 8'h00, 1'b0, 8'h00, 8'h00);

    // Short instance: out-of-range fetch, dropped load, no aliasing
    drive(1'b1, 8'h10, 1'b0, 8'h00, 8'h00);
    tick();
    chk("oor_fetch_b", {iv_b, ff_b, in_b}, {2'b11, 8'h5A});
    chk("inrange_fetch_a", {iv_a, ff_a, in_a}, {2'b10, 8'h3C});
    drive(1'b0, 8'h00, 1'b1, 8'h10, 8'h77);
    tick();
    chk("oor_load_quiet_b", {iv_b, ff_b, in_b}, {2'b00, 8'h5A});
    drive(1'b1, 8'h00, 1'b0, 8'h00, 8'h00);
    tick();
    chk("no_alias_b", {iv_b, ff_b, in_b}, {2'b10, 8'h5A});
    drive(1'b1, 8'hFF, 1'b0, 8'h00, 8'h00);
    tick();
    chk("oor_top_b", {iv_b, ff_b, in_b}, {2'b11, 8'h5A});
    drive(1'b1, 8'h10, 1'b0, 8'h00, 8'h00);
    tick();
    chk("reload_a", {iv_a, ff_a, in_a}, {2'b10, 8'h77});
    drive(1'b0, 8'h00, 1'b0, 8'h00, 8'h00);
    tick();
    chk("fault_pulse_b", {iv_b, ff_b}, 2'b00);

    // Reset while a fetch is pending: no valid pulse
    drive(1'b1, 8'h31, 1'b0, 8'h00, 8'h00);
    #3 reset = 1'b1;
    #1;
    chk("midfetch_rst_a", {iv_a, in_a, busy_a}, {1'b0, 8'h00, 1'b1});
    tick();
    chk("midfetch_after_a", {iv_a, ff_a, fr_a}, 3'b000);
    chk("midfetch_after_b", {iv_b, ff_b, fr_b}, 3'b000);
    @(negedge clk);
    clear_wait("midfetch");

    // Reset in the middle of a clear, with the counter at 100
    reset = 1'b1;
    tick();
    @(negedge clk);
    reset = 1'b0;
    repeat (100) tick();
    chk("midclear_busy_a", busy_a, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    tick();
    chk("midclear_rst_a", {busy_a, fr_a, iv_a}, 3'b100);
    @(negedge clk);
    clear_wait("midclear");

    // Array was really cleared by the restarted sequence
    drive(1'b1, 8'h31, 1'b0, 8'h00, 8'h00);
    tick();
    chk("cleared_31_a", {iv_a, ff_a, in_a}, {2'b10, 8'h00});
    drive(1'b1, 8'h10, 1'b0, 8'h00, 8'h00);
    tick();
    chk("cleared_10_a", {iv_a, ff_a, in_a}, {2'b10, 8'h00});
    drive(1'b1, 8'h01, 1'b0, 8'h00, 8'h00);
    tick();
    chk("cleared_01_b", {iv_b, ff_b, in_b}, {2'b10, 8'h5A});
    drive(1'b0, 8'h00, 1'b0, 8'h00, 8'h00);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Absolute time limit in case something stalls.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/instruction_mem_sync.md
Name: instruction_mem_sync

Overview:
Parametrised synchronous instruction memory; successor to the combinational, DPI-backed instruction store.
- Clocked fetch port with request/valid handshake, 1-cycle latency.
- Write (load) port lets the test bench or boot loader program the memory at run time.
- Hardware clear sequencer zeroes the array after reset, replacing simulation-only initialisation.
- Sits between the control unit (fetch at PC) and the program loader.

Parameters:
INSTR_WIDTH, 8, width of one instruction word in bits
PC_WIDTH, 8, width of fetch and load addresses
DEPTH, 256, number of words implemented; must be <= 2**PC_WIDTH
FILL_VALUE, 0, word written by the clear sequencer and returned on out-of-range fetch

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-high reset
fetch_req  input  1  fetch request; sampled when fetch_ready=1
pc  input  PC_WIDTH  fetch address, sampled with fetch_req
fetch_ready  output  1  memory accepts fetches (state IDLE)
instruction  output  INSTR_WIDTH  fetched word, registered
instr_valid  output  1  one-cycle pulse: instruction holds data for the fetch accepted last cycle
fetch_fault  output  1  one-cycle pulse alongside instr_valid when fetched pc >= DEPTH
load_valid  input  1  write request
load_addr  input  PC_WIDTH  write address
load_data  input  INSTR_WIDTH  write data
load_ready  output  1  write accepted this cycle when load_valid=1 (state IDLE)
busy  output  1  clear sequence in progress

Behaviour:
- Reset (async, active-high) forces:
  - state=CLEAR, clear counter=0
  - instruction=0, instr_valid=0, fetch_fault=0
  - fetch_ready=0, load_ready=0, busy=1
- Reset asserted mid-clear, mid-fetch or mid-load restarts the clear from address 0. A fetch in flight is discarded: no instr_valid pulse.
- State CLEAR:
  - Each cycle writes FILL_VALUE to array[counter], then counter+1.
  - After writing DEPTH-1, state goes to IDLE.
  - CLEAR lasts exactly DEPTH cycles after reset deasserts.
  - fetch_req and load_valid are ignored (not queued).
- State IDLE: fetch_ready=1, load_ready=1, busy=0; there is no other state.
- Fetch:
  - fetch_req=1 at edge N captures pc.
  - At edge N+1, instruction=array[pc] and instr_valid=1 for one cycle.
  - Back-to-back requests are accepted every cycle, giving one valid per cycle with throughput 1.
  - With no request, instr_valid=0 and instruction holds its last value. The output is never Z.
- Out-of-range fetch (pc >= DEPTH): instruction=FILL_VALUE and instr_valid=1, with fetch_fault=1 in the same cycle. The array is not accessed.
- Load:
  - load_valid=1 with load_ready=1 at edge N writes load_data to array[load_addr].
  - The new value is visible to fetches accepted at edge N+1 or later.
  - Out-of-range load_addr (>= DEPTH) is dropped silently. No fault is raised and no word is aliased.
- Simultaneous fetch and load, same address, same edge: read-before-write. The fetch returns the old word and the write completes.
- Simultaneous fetch and load, different addresses: both complete independently.
- Address widths: pc and load_addr are used unsigned, with no wrap. The comparison against DEPTH uses the full PC_WIDTH value.
- Implementation:
  - Single-port-write, single-port-read registered array, inferable as block RAM.
  - The clear counter is PC_WIDTH+1 bits, so DEPTH = 2**PC_WIDTH terminates correctly.

Test Plan:
1. Reset pulse with DEPTH=256 -> busy=1 and fetch_ready=0 for exactly 256 cycles after deassert. Then fetch pc=0x00, 0x7F and 0xFF -> each returns 0x00 with instr_valid pulsed.
2. Load 0x3C to addr 0x10, then fetch pc=0x10 on the next cycle -> instruction=0x3C, instr_valid=1 exactly one cycle after the request, fetch_fault=0.
3. Back-to-back fetches pc=1,2,3 over consecutive cycles after loading 0xA1, 0xA2, 0xA3 -> instruction sequence 0xA1, 0xA2, 0xA3 on three consecutive cycles, each with instr_valid=1.
4. Collision: addr 0x20 holds 0x11; same edge loads 0x22 to 0x20 and fetches pc=0x20 -> instruction=0x11. The following fetch of 0x20 returns 0x22.
5. DEPTH=16, PC_WIDTH=8: fetch pc=0x10 -> instruction=FILL_VALUE, instr_valid=1, fetch_fault=1. Load to 0x10 then fetch 0x00 -> word 0x00 unchanged (no alias).
6. Reset mid-operation: assert reset during clear at counter=100, and again during a pending fetch -> no instr_valid pulse. The clear restarts and busy stays high for a full DEPTH cycles after deassert. Fetch and load requests made during CLEAR have no effect.
